// File: rtl/scan_sequencer.sv
// ---------------------------------------------------------------------------
// scan_sequencer
//   Drives the select code and enable of a 3-to-8 decoder. It walks codes
//   0..7 (or 7..0) and holds each code enabled for a programmable dwell.
//   Between codes it inserts BLANK_CYC enable-low cycles, so two decoder
//   outputs are never hot at the same time. It supports one-shot and
//   free-running scans.
//
// Parameters
//   DWELL_W    width of the dwell input and the dwell counter
//   BLANK_CYC  enable-low cycles between codes (0 = no blanking)
//
// Ports
//   clka      in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   start     in   begin a scan (honoured in IDLE only)
//   stop      in   abort the scan (wins over start)
//   oneshot   in   1 = single pass, 0 = free-run (latched at start)
//   dir_down  in   1 = 7..0, 0 = 0..7 (latched at start)
//   dwell     in   enabled cycles per code, 0 treated as 1 (latched at start)
//   sel_out   out  select code to the decoder
//   en_out    out  enable to the decoder
//   busy      out  high whenever not IDLE
//   wrap      out  pulse on the first cycle the wrapped code is shown
//   done      out  pulse when a one-shot pass completes
//   All outputs are registered.
// ---------------------------------------------------------------------------
module scan_sequencer #(
  parameter int unsigned DWELL_W   = 8,
  parameter int unsigned BLANK_CYC = 1
) (
  input  logic               clka,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               oneshot,
  input  logic               dir_down,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel_out,
  output logic               en_out,
  output logic               busy,
  output logic               wrap,
  output logic               done
);

  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_sel, w_sel_nxt;
  logic               r_en, w_en_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_wrap, w_wrap_nxt;
  logic               r_done, w_done_nxt;
  logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;   // dwell cycles remaining after this one
  logic [BW-1:0]      r_bcnt, w_bcnt_nxt; // blank cycles remaining after this one
  logic [DWELL_W-1:0] r_last, w_last_nxt; // latched D-1
  logic               r_dir, w_dir_nxt;
  logic               r_one, w_one_nxt;

  logic               w_final;
  logic [2:0]         w_sel_step;

  // Last code of the pass in the latched direction.
  assign w_final    = r_dir ? (r_sel == 3'd0) : (r_sel == 3'd7);
  assign w_sel_step = r_dir ? (r_sel - 3'd1) : (r_sel + 3'd1);

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_wrap  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_bcnt  <= '0;
      r_last  <= '0;
      r_dir   <= 1'b0;
      r_one   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= w_busy_nxt;
      r_wrap  <= w_wrap_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_last  <= w_last_nxt;
      r_dir   <= w_dir_nxt;
      r_one   <= w_one_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_en_nxt    = r_en;
    w_busy_nxt  = r_busy;
    w_wrap_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_bcnt_nxt  = r_bcnt;
    w_last_nxt  = r_last;
    w_dir_nxt   = r_dir;
    w_one_nxt   = r_one;

    if (r_state == IDLE) begin
      w_en_nxt   = 1'b0;
      w_busy_nxt = 1'b0;
      if (start && !stop) begin
        w_state_nxt = DWELL;
        w_sel_nxt   = dir_down ? 3'd7 : 3'd0;
        w_en_nxt    = 1'b1;
        w_busy_nxt  = 1'b1;
        w_dir_nxt   = dir_down;
        w_one_nxt   = oneshot;
        // A dwell of 0 behaves like 1, so D-1 saturates at 0.
        w_last_nxt  = (dwell == '0) ? '0 : dwell - 1'b1;
        w_cnt_nxt   = (dwell == '0) ? '0 : dwell - 1'b1;
      end
    end else if (stop) begin
      // Abort: the select code holds, and no done or wrap pulse is issued.
      w_state_nxt = IDLE;
      w_en_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
      w_cnt_nxt   = '0;
      w_bcnt_nxt  = '0;
    end else begin
      unique case (r_state)
        DWELL: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 1'b1;
          end else if (w_final && r_one) begin
            w_state_nxt = IDLE;
            w_en_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            // In this branch, a final code implies free-run, so stepping
            // past it wraps.
            w_sel_nxt  = w_sel_step;
            w_wrap_nxt = w_final;
            if (BLANK_CYC > 0) begin
              w_state_nxt = BLANK;
              w_en_nxt    = 1'b0;
              w_bcnt_nxt  = BLANK_LAST;
            end else begin
              w_cnt_nxt = r_last;
            end
          end
        end
        BLANK: begin
          if (r_bcnt != '0) begin
            w_bcnt_nxt = r_bcnt - 1'b1;
          end else begin
            w_state_nxt = DWELL;
            w_en_nxt    = 1'b1;
            w_cnt_nxt   = r_last;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_en_nxt    = 1'b0;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign sel_out = r_sel;
  assign en_out  = r_en;
  assign busy    = r_busy;
  assign wrap    = r_wrap;
  assign done    = r_done;

endmodule

// File: tb/tb_scan_sequencer.sv
// ---------------------------------------------------------------------------
// tb_scan_sequencer
//   Two instances share the same stimulus. One uses BLANK_CYC=1 and the
//   other uses BLANK_CYC=0. The reference model describes a scan as a
//   position u on a periodic timeline. Each code occupies B blank cycles
//   followed by D enabled cycles. The first code's blank is virtual, so a
//   scan starts at u=B. The driver pushes the expected outputs for each
//   edge. A monitor pops one entry per edge and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_scan_sequencer;

  typedef struct packed {
    logic [2:0] sel;
    logic       en;
    logic       busy;
    logic       wrap;
    logic       done;
  } out_t;

  typedef struct {
    bit         act;
    int         u;
    int         d;
    int         b;
    bit         dir;
    bit         one;
    logic [2:0] hold;
  } mdl_t;

  logic       clka = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       oneshot = 1'b0;
  logic       dir_down = 1'b0;
  logic [7:0] dwell = 8'd0;

  logic [2:0] sel1, sel0;
  logic       en1, busy1, wrap1, done1;
  logic       en0, busy0, wrap0, done0;

  out_t q1[$];
  out_t q0[$];
  out_t e1, e0;
  mdl_t m1, m0;
  int   checks = 0;
  int   errors = 0;

  always #5 clka = ~clka;

  scan_sequencer #(.DWELL_W(8), .BLANK_CYC(1)) u_dut1 (
    .clka(clka), .rst(rst), .start(start), .stop(stop), .oneshot(oneshot),
    .dir_down(dir_down), .dwell(dwell), .sel_out(sel1), .en_out(en1),
    .busy(busy1), .wrap(wrap1), .done(done1)
  );

  scan_sequencer #(.DWELL_W(8), .BLANK_CYC(0)) u_dut0 (
    .clka(clka), .rst(rst), .start(start), .stop(stop), .oneshot(oneshot),
    .dir_down(dir_down), .dwell(dwell), .sel_out(sel0), .en_out(en0),
    .busy(busy0), .wrap(wrap0), .done(done0)
  );

  task automatic cmp(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got sel=%0d en=%b busy=%b wrap=%b done=%b want sel=%0d en=%b busy=%b wrap=%b done=%b",
               name, $time, got.sel, got.en, got.busy, got.wrap, got.done,
               exp.sel, exp.en, exp.busy, exp.wrap, exp.done);
    end
  endtask

  // Expected outputs at timeline position u of an active scan.
  function automatic out_t at_pos(input mdl_t m);
    out_t o;
    int   p, k, ph, c;
    p  = m.d + m.b;
    k  = m.u / p;
    ph = m.u % p;
    c  = k % 8;
    o.sel  = m.dir ? 3'(7 - c) : 3'(c);
    o.en   = (ph >= m.b);
    o.busy = 1'b1;
    o.wrap = (k > 0) && (c == 0) && (ph == 0);
    o.done = 1'b0;
    return o;
  endfunction

  // Outputs after the coming edge, given the inputs applied now.
  task automatic model_step(inout mdl_t m, output out_t o);
    o     = '0;
    o.sel = m.hold;
    if (rst) begin
      m.act  = 1'b0;
      m.hold = 3'd0;
      o      = '0;
    end else if (m.act) begin
      if (stop) begin
        m.act = 1'b0;
      end else begin
        m.u++;
        if (m.one && m.u == 8 * (m.d + m.b)) begin
          m.act  = 1'b0;
          o.done = 1'b1;
        end else begin
          o      = at_pos(m);
          m.hold = o.sel;
        end
      end
    end else if (start && !stop) begin
      m.act  = 1'b1;
      m.dir  = dir_down;
      m.one  = oneshot;
      m.d    = (dwell == 8'd0) ? 1 : int'(dwell);
      m.u    = m.b;
      o      = at_pos(m);
      m.hold = o.sel;
    end
  endtask

  task automatic step();
    out_t o;
    model_step(m1, o);
    q1.push_back(o);
    model_step(m0, o);
    q0.push_back(o);
    @(posedge clka);
    @(negedge clka);
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    stop  = 1'b0;
    repeat (n) step();
  endtask

  task automatic go(input bit one, input bit dn, input int dw);
    oneshot  = one;
    dir_down = dn;
    dwell    = 8'(dw);
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // Monitor: one expected entry per edge, compared just after the edge.
  always @(posedge clka) begin
    #1;
    if (q1.size() > 0 && q0.size() > 0) begin
      e1 = q1.pop_front();
      e0 = q0.pop_front();
      cmp("blank1", {sel1, en1, busy1, wrap1, done1}, e1);
      cmp("blank0", {sel0, en0, busy0, wrap0, done0}, e0);
    end
  end

  initial begin
    m1 = '{act: 1'b0, u: 0, d: 1, b: 1, dir: 1'b0, one: 1'b0, hold: 3'd0};
    m0 = '{act: 1'b0, u: 0, d: 1, b: 0, dir: 1'b0, one: 1'b0, hold: 3'd0};

    // Reset state.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    idle(2);

    // Up one-shot, dwell 2.
    go(1'b1, 1'b0, 2);
    idle(28);

    // Down free-run, dwell 1: wraps 0->7.
    go(1'b0, 1'b1, 1);
    idle(24);
    pulse_stop();
    idle(2);

    // Dwell 0 behaves like dwell 1.
    go(1'b0, 1'b0, 0);
    idle(20);
    pulse_stop();
    idle(1);

    // Stop mid-scan around code 3, then restart from 0.
    go(1'b1, 1'b0, 2);
    idle(9);
    pulse_stop();
    idle(3);
    go(1'b1, 1'b0, 2);
    idle(5);
    pulse_stop();
    idle(1);

    // Start and stop together in IDLE; stop while idle.
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    idle(1);
    pulse_stop();
    idle(1);

    // Start while busy is ignored, including changed settings.
    go(1'b1, 1'b0, 1);
    idle(3);
    oneshot  = 1'b0;
    dir_down = 1'b1;
    dwell    = 8'd5;
    start    = 1'b1;
    step();
    start    = 1'b0;
    idle(20);

    // Asynchronous reset mid-dwell.
    go(1'b0, 1'b0, 3);
    idle(2);
    rst = 1'b1;
    #1;
    cmp("async_rst1", {sel1, en1, busy1, wrap1, done1}, '0);
    cmp("async_rst0", {sel0, en0, busy0, wrap0, done0}, '0);
    step();
    step();
    rst = 1'b0;
    idle(2);
    go(1'b1, 1'b1, 2);
    idle(30);

    // Random traffic.
    repeat (500) begin
      start    = ($urandom_range(0, 3) == 0);
      stop     = ($urandom_range(0, 29) == 0);
      oneshot  = 1'($urandom_range(0, 1));
      dir_down = 1'($urandom_range(0, 1));
      dwell    = 8'($urandom_range(0, 3));
      step();
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
